slide_pot_reader: RTL

- SPI master that continuously sweeps a 6-channel 12-bit A2D connected to the equalizer slide pots and volume pot.
- Holds the latest reading of every channel in output registers, already formatted as the 24-bit POT words the band-gain stages consume.
- Sits between the board's A2D pins and the per-band scaling stages; it is the producer of every POT value in the datapath.

---
 rtl/eq_pkg.sv | 30 +++
 rtl/slide_pot_reader_if.sv | 10 +
 rtl/spi_mstr16.sv | 94 +++++++++
 rtl/slide_pot_reader.sv | 81 ++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared constants, channel map and SPI sequencer state encoding for the equalizer pot
// reader.
package eq_pkg;

  localparam int unsigned NUM_POT_CH = 6;
  localparam int unsigned POT_ADC_W  = 12;
  localparam int unsigned POT_W      = 24;

  localparam logic [2:0] CH_LP  = 3'd0;
  localparam logic [2:0] CH_B1  = 3'd1;
  localparam logic [2:0] CH_B2  = 3'd2;
  localparam logic [2:0] CH_B3  = 3'd3;
  localparam logic [2:0] CH_HP  = 3'd4;
  localparam logic [2:0] CH_VOL = 3'd5;

  typedef logic [1:0] spi_state_t;
  localparam spi_state_t StGap   = 2'd0;
  localparam spi_state_t StFrame = 2'd1;
  localparam spi_state_t StBack  = 2'd2;

  // Channel pointer sweeps 0..5 and wraps; addresses 6 and 7 are never issued.
  function automatic logic [2:0] next_ch(logic [2:0] ch);
    return (ch == CH_VOL) ? CH_LP : ch + 3'd1;
  endfunction

  function automatic logic [15:0] mosi_word(logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/slide_pot_reader_if.sv
// A2D SPI pin bundle; the reader is the master, the converter the slave.
interface slide_pot_reader_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_mstr16.sv
// Free-running 16-bit SPI master: gap, 16 SCLK pulses (mode 3 style, idle high),
// back-porch, then a one-clk done pulse coincident with SS_n rising.
module spi_mstr16
  import eq_pkg::*;
#(
  parameter int unsigned HALF = 16,
  parameter int unsigned GAP  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tx_word,
  output logic [15:0] rx_word,
  output logic        done,
  slide_pot_reader_if.master spi
);

  localparam int unsigned CntMax = (GAP > HALF) ? GAP : HALF;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);

  spi_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic            sclk_q;
  logic            ss_n_q;
  logic [15:0]     tx_q;
  logic [15:0]     rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StGap;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      ss_n_q  <= 1'b1;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      case (state_q)
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q <= StFrame;
            cnt_q   <= '0;
            bit_q   <= '0;
            ss_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            tx_q    <= tx_word;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFrame: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              // MISO is captured on the same clk that raises SCLK.
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[14:0], spi.MISO};
            end else if (bit_q == 4'd15) begin
              state_q <= StBack;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 4'd1;
              tx_q   <= {tx_q[14:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBack: begin
          if (cnt_q == HalfLast) begin
            state_q <= StGap;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StGap;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign done     = (state_q == StBack) && (cnt_q == HalfLast);
  assign rx_word  = rx_q;
  assign spi.SS_n = ss_n_q;
  assign spi.SCLK = sclk_q;
  assign spi.MOSI = tx_q[15];

endmodule

// File: rtl/slide_pot_reader.sv
// Sweeps the six-channel pot A2D and holds the latest reading of each channel as a
// 24-bit POT word; accounts for the converter's one-frame result pipeline.
module slide_pot_reader
  import eq_pkg::*;
#(
  parameter int unsigned HALF = 16,
  parameter int unsigned GAP  = 32
) (
  input  logic             clk,
  input  logic             rst,
  slide_pot_reader_if.master spi,
  output logic [POT_W-1:0] POT_LP,
  output logic [POT_W-1:0] POT_B1,
  output logic [POT_W-1:0] POT_B2,
  output logic [POT_W-1:0] POT_B3,
  output logic [POT_W-1:0] POT_HP,
  output logic [POT_W-1:0] VOLUME,
  output logic             sweep_done
);

  logic [15:0]      rx_word;
  logic             done;
  logic [2:0]       ptr_q;
  logic [2:0]       prev_addr_q;
  logic             discard_q;
  logic             sweep_done_q;
  logic [POT_W-1:0] pot_q [NUM_POT_CH];
  logic             unused_rx_hi;

  spi_mstr16 #(
    .HALF (HALF),
    .GAP  (GAP)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .tx_word (mosi_word(ptr_q)),
    .rx_word (rx_word),
    .done    (done),
    .spi     (spi)
  );

  // The converter's status nibble carries no data for us.
  assign unused_rx_hi = ^rx_word[15:POT_ADC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= CH_LP;
      prev_addr_q  <= CH_LP;
      discard_q    <= 1'b1;
      sweep_done_q <= 1'b0;
      for (int i = 0; i < NUM_POT_CH; i++) pot_q[i] <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      if (done) begin
        // Data in this frame answers the address sent in the previous one; the very
        // first frame after reset has no predecessor and is dropped.
        if (discard_q) begin
          discard_q <= 1'b0;
        end else begin
          for (int i = 0; i < NUM_POT_CH; i++) begin
            if (prev_addr_q == 3'(i)) begin
              pot_q[i] <= {rx_word[POT_ADC_W-1:0], {(POT_W - POT_ADC_W){1'b0}}};
            end
          end
          sweep_done_q <= (prev_addr_q == CH_VOL);
        end
        prev_addr_q <= ptr_q;
        ptr_q       <= next_ch(ptr_q);
      end
    end
  end

  assign POT_LP     = pot_q[CH_LP];
  assign POT_B1     = pot_q[CH_B1];
  assign POT_B2     = pot_q[CH_B2];
  assign POT_B3     = pot_q[CH_B3];
  assign POT_HP     = pot_q[CH_HP];
  assign VOLUME     = pot_q[CH_VOL];
  assign sweep_done = sweep_done_q;

endmodule
